// File: rtl/stream_pkt_gen_if.sv
// Byte-stream valid/ready/last bundle between a packet source (master) and its sink (slave).
interface stream_pkt_gen_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic              s_ready;

   modport master (output s_data, output s_valid, output s_last, input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/stream_pkt_gen.sv
// Packet generator: one packet of incrementing bytes per start, backpressure-aware, counts packets.
// Define PKT_GEN_CHECKSUM_EN to append an XOR checksum beat to every packet.
module stream_pkt_gen #(
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 8,
   parameter int CNT_W      = 16,
   parameter int GAP_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [LEN_W-1:0]    pkt_len,
   input  logic [DATA_W-1:0]   seed,
   stream_pkt_gen_if.master    strm,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    pkt_cnt
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

`ifdef PKT_GEN_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SEND, CSUM, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif

   state_t              state_reg, state_next;
   logic [LEN_W-1:0]    len_reg, len_next;
   logic [LEN_W-1:0]    beat_reg, beat_next;
   logic [DATA_W-1:0]   data_reg, data_next;
   logic                valid_reg, valid_next;
   logic                last_reg, last_next;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [GAP_W-1:0]    gap_reg, gap_next;
   logic                xfer;
   logic                finish;
`ifdef PKT_GEN_CHECKSUM_EN
   logic [DATA_W-1:0]   csum_reg, csum_next;
`endif

   assign xfer = valid_reg & strm.s_ready;

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      beat_next  = beat_reg;
      data_next  = data_reg;
      valid_next = valid_reg;
      last_next  = last_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      cnt_next   = cnt_reg;
      gap_next   = gap_reg;
      finish     = 1'b0;
`ifdef PKT_GEN_CHECKSUM_EN
      csum_next  = csum_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (start && (pkt_len != '0)) begin
               state_next = SEND;
               len_next   = pkt_len;
               beat_next  = '0;
               data_next  = seed;
               valid_next = 1'b1;
               busy_next  = 1'b1;
`ifdef PKT_GEN_CHECKSUM_EN
               last_next  = 1'b0;
               csum_next  = '0;
`else
               last_next  = (pkt_len == LEN_W'(1));
`endif
            end
         end
         SEND: begin
            if (xfer) begin
`ifdef PKT_GEN_CHECKSUM_EN
               csum_next = csum_reg ^ data_reg;
`endif
               if (beat_reg == len_reg - LEN_W'(1)) begin
`ifdef PKT_GEN_CHECKSUM_EN
                  // Checksum beat folds in the final data byte being transferred now.
                  state_next = CSUM;
                  data_next  = csum_reg ^ data_reg;
                  last_next  = 1'b1;
`else
                  finish = 1'b1;
`endif
               end else begin
                  beat_next = beat_reg + LEN_W'(1);
                  data_next = data_reg + DATA_W'(1);
`ifdef PKT_GEN_CHECKSUM_EN
                  last_next = 1'b0;
`else
                  last_next = (beat_reg + LEN_W'(1) == len_reg - LEN_W'(1));
`endif
               end
            end
         end
`ifdef PKT_GEN_CHECKSUM_EN
         CSUM: begin
            if (xfer) finish = 1'b1;
         end
`endif
         GAP: begin
            if (gap_reg == '0) begin
               state_next = IDLE;
               busy_next  = 1'b0;
            end else begin
               gap_next = gap_reg - GAP_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            valid_next = 1'b0;
            last_next  = 1'b0;
         end
      endcase

      // Common end-of-packet bookkeeping, shared by the data and checksum paths.
      if (finish) begin
         valid_next = 1'b0;
         last_next  = 1'b0;
         done_next  = 1'b1;
         cnt_next   = cnt_reg + CNT_W'(1);
         if (GAP_CYCLES == 0) begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end else begin
            state_next = GAP;
            gap_next   = GAP_LOAD;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         len_reg   <= '0;
         beat_reg  <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         cnt_reg   <= '0;
         gap_reg   <= '0;
`ifdef PKT_GEN_CHECKSUM_EN
         csum_reg  <= '0;
`endif
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         beat_reg  <= beat_next;
         data_reg  <= data_next;
         valid_reg <= valid_next;
         last_reg  <= last_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         cnt_reg   <= cnt_next;
         gap_reg   <= gap_next;
`ifdef PKT_GEN_CHECKSUM_EN
         csum_reg  <= csum_next;
`endif
      end
   end

   assign strm.s_data  = data_reg;
   assign strm.s_valid = valid_reg;
   assign strm.s_last  = last_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign pkt_cnt      = cnt_reg;

endmodule

// File: tb/tb_stream_pkt_gen.sv
// Scoreboard bench for stream_pkt_gen: stimulus pushes expected beats, a negedge monitor pops and checks.
module tb_stream_pkt_gen;

`ifdef PKT_GEN_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam int PERIOD6 = CSUM ? 5 : 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  pkt_len;
   logic [7:0]  seed;
   logic        busy;
   logic        done;
   logic [15:0] pkt_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [8:0] exp_q[$];

   stream_pkt_gen_if #(.DATA_W(8)) bus ();

   stream_pkt_gen #(
      .DATA_W(8), .LEN_W(8), .CNT_W(16), .GAP_CYCLES(2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pkt_len (pkt_len),
      .seed    (seed),
      .strm    (bus.master),
      .busy    (busy),
      .done    (done),
      .pkt_cnt (pkt_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   // Monitor: compares every accepted beat, stall stability and the done pulse.
   logic       stall = 1'b0;
   logic [8:0] hold_beat;
   logic       done_exp = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         stall    = 1'b0;
         done_exp = 1'b0;
      end else begin
         if (done_exp || done) check("done_pulse", {31'd0, done}, {31'd0, done_exp});
         done_exp = 1'b0;
         if (stall) begin
            check("hold_valid", {31'd0, bus.s_valid}, 32'd1);
            check("hold_beat", {23'd0, bus.s_last, bus.s_data}, {23'd0, hold_beat});
         end
         stall = 1'b0;
         if (bus.s_valid && bus.s_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", bus.s_data, bus.s_last);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("beat", {23'd0, bus.s_last, bus.s_data}, {23'd0, e});
               if (e[8]) done_exp = 1'b1;
            end
         end else if (bus.s_valid) begin
            stall     = 1'b1;
            hold_beat = {bus.s_last, bus.s_data};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, n;
      reset = 1'b1; start = 1'b0; pkt_len = '0; seed = '0; bus.s_ready = 1'b1;
      tick(); tick(); tick();
      check("rst_valid", {31'd0, bus.s_valid}, 32'd0);
      check("rst_last",  {31'd0, bus.s_last}, 32'd0);
      check("rst_data",  {24'd0, bus.s_data}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_cnt",   {16'd0, pkt_cnt}, 32'd0);
      reset = 1'b0;
      tick();

      // 1: basic packet
      push(8'h11, 1'b0); push(8'h12, 1'b0); push(8'h13, 1'b0); push(8'h14, !CSUM);
      if (CSUM) push(8'h04, 1'b1);
      seed = 8'h11; pkt_len = 8'd4; start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_first_valid", {31'd0, bus.s_valid}, 32'd1);
      check("t1_first_data", {24'd0, bus.s_data}, 32'h11);
      check("t1_busy", {31'd0, busy}, 32'd1);
      wait_idle();
      check("t1_cnt", {16'd0, pkt_cnt}, 32'd1);

      // 2: backpressure on beat 0x21
      push(8'h20, 1'b0); push(8'h21, 1'b0); push(8'h22, 1'b0); push(8'h23, !CSUM);
      if (CSUM) push(8'h00, 1'b1);
      seed = 8'h20; pkt_len = 8'd4; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      bus.s_ready = 1'b0;
      tick(); tick();
      check("t2_held_data", {24'd0, bus.s_data}, 32'h21);
      bus.s_ready = 1'b1;
      wait_idle();
      check("t2_cnt", {16'd0, pkt_cnt}, 32'd2);

      // 3: data wrap
      push(8'hFE, 1'b0); push(8'hFF, 1'b0); push(8'h00, !CSUM);
      if (CSUM) push(8'h01, 1'b1);
      seed = 8'hFE; pkt_len = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle();
      check("t3_cnt", {16'd0, pkt_cnt}, 32'd3);

      // 4: start during SEND and zero-length start are ignored
      push(8'h30, 1'b0); push(8'h31, 1'b0); push(8'h32, 1'b0); push(8'h33, 1'b0); push(8'h34, !CSUM);
      if (CSUM) push(8'h34, 1'b1);
      seed = 8'h30; pkt_len = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      seed = 8'h99; pkt_len = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle();
      check("t4_cnt", {16'd0, pkt_cnt}, 32'd4);
      seed = 8'h55; pkt_len = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_zero_busy", {31'd0, busy}, 32'd0);
      check("t4_zero_valid", {31'd0, bus.s_valid}, 32'd0);
      tick();
      check("t4_zero_cnt", {16'd0, pkt_cnt}, 32'd4);

      // 5: async reset mid-packet
      push(8'h50, 1'b0); push(8'h51, 1'b0);
      seed = 8'h50; pkt_len = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b1;
      #1;
      check("t5_rst_valid", {31'd0, bus.s_valid}, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_cnt", {16'd0, pkt_cnt}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      push(8'h40, 1'b0); push(8'h41, !CSUM);
      if (CSUM) push(8'h01, 1'b1);
      seed = 8'h40; pkt_len = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle();
      check("t5_cnt", {16'd0, pkt_cnt}, 32'd1);

      // 6: single-beat packets back to back with start held high
      push(8'hAA, !CSUM); if (CSUM) push(8'hAA, 1'b1);
      push(8'hAA, !CSUM); if (CSUM) push(8'hAA, 1'b1);
      seed = 8'hAA; pkt_len = 8'd1; start = 1'b1;
      tick();
      check("t6_first_valid", {31'd0, bus.s_valid}, 32'd1);
      check("t6_first_last", {31'd0, bus.s_last}, {31'd0, !CSUM});
      t0 = cyc;
      n = 0;
      while (bus.s_valid && n < 20) begin tick(); n++; end
      while (!bus.s_valid && n < 20) begin tick(); n++; end
      t1 = cyc;
      start = 1'b0;
      check("t6_period", t1 - t0, PERIOD6);
      wait_idle();
      check("t6_cnt", {16'd0, pkt_cnt}, 32'd3);

      tick(); tick();
      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
